mem_block_responder: RTL and testbench

- Synthesizable block-memory responder: the slave end of the 128-bit cache/memory interface (mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_ready).
- Holds 2^IDX_W blocks of 128 bits and answers each request after a programmable fixed latency with a one-cycle mem_ready pulse.
- Used as the memory behind the read-only and future write-back caches in simulation and FPGA bring-up.

---
 rtl/mem_block_responder.sv | 215 +++++++++++++++++++++
 tb/tb_mem_block_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_block_responder.sv
// -----------------------------------------------------------------------------
// mem_block_responder
//
// Slave end of the 128-bit cache/memory block interface. Holds 2^IDX_W blocks
// of 128 bits. A request is sampled in IDLE. After a fixed latency, the
// responder answers with a one-cycle mem_ready pulse.
//
// Parameters
//   IDX_W    number of mem_addr LSBs used as the block index (depth 2^IDX_W)
//   LATENCY  cycles from the request-sampling edge to mem_ready (1..15)
//
// Ports
//   clk         clock; all logic runs on its rising edge
//   proc_reset  synchronous, active-high reset. It clears the FSM, the outputs
//               and all of storage.
//   mem_read    block read request; held by the initiator until mem_ready
//   mem_write   block write request; held by the initiator until mem_ready
//   mem_addr    block address; bits above IDX_W-1 are ignored (aliasing)
//   mem_wdata   write block data; word k is at bits [32k+31:32k]
//   mem_rdata   read block data. It is non-zero only during the mem_ready cycle.
//   mem_ready   one-cycle completion pulse
//   proto_err   (only with MEM_PROTO_CHECK_EN) sticky protocol-violation flag
//
// Optional feature macro: MEM_PROTO_CHECK_EN
// -----------------------------------------------------------------------------
module mem_block_responder #(
    parameter int IDX_W   = 6,
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready
`ifdef MEM_PROTO_CHECK_EN
    ,
    output logic         proto_err
`endif
);

    localparam int         DEPTH  = 2 ** IDX_W;
    // The count is loaded with LATENCY-1 at sampling. The access happens on
    // the edge where the count is already zero. This makes mem_ready rise on
    // edge E0+LATENCY for every legal LATENCY, including 1.
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         count_q, count_d;
    logic               wr_q, wr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [127:0]       wdata_q, wdata_d;
    logic [127:0]       rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               mem_we_s;
    logic [127:0]       storage_q [DEPTH];

    // The upper address bits alias by design. They are only consumed when
    // the protocol checker is built.
    logic               unused_addr_s;
    assign unused_addr_s = ^mem_addr[27:IDX_W];

    // Next-state, datapath and response logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        wr_d     = wr_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        mem_we_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    // Write wins when both request lines are high.
                    wr_d    = mem_write;
                    idx_d   = mem_addr[IDX_W-1:0];
                    wdata_d = mem_wdata;
                    count_d = LAT_M1;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (count_q == 4'd0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (wr_q) begin
                        // Commit before RESP, so a following read needs no bypass.
                        mem_we_s = 1'b1;
                        rdata_d  = wdata_q;
                    end else begin
                        rdata_d  = storage_q[idx_q];
                    end
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = 128'd0;
                ready_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                rdata_d = 128'd0;
                ready_d = 1'b0;
            end
        endcase
    end

    // FSM and transaction registers.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= IDLE;
            count_q <= 4'd0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 128'd0;
            rdata_q <= 128'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // Block storage. Reset clears every block.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage_q[i] <= 128'd0;
            end
        end else if (mem_we_s) begin
            storage_q[idx_q] <= wdata_q;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;

`ifdef MEM_PROTO_CHECK_EN
    logic [27:0] addr_q, addr_d;
    logic        proto_q, proto_d;

    // Protocol checking. In BUSY the request must stay up with a stable
    // address. In RESP the initiator may already have seen mem_ready and
    // dropped its request, so only an address change under a still-held
    // request is flagged there.
    always_comb begin
        addr_d  = addr_q;
        proto_d = proto_q;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d = mem_addr;
                end else begin
                    addr_d = addr_q;
                end
                if (mem_read && mem_write) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
            end
            BUSY: begin
                if (!(mem_read || mem_write) || (mem_addr != addr_q)) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
            end
            RESP: begin
                if ((mem_read || mem_write) && (mem_addr != addr_q)) begin
                    proto_d = 1'b1;
                end else begin
                    proto_d = proto_q;
                end
            end
            default: begin
                proto_d = proto_q;
            end
        endcase
    end

    // Latched request address and sticky error flag.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            addr_q  <= 28'd0;
            proto_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            proto_q <= proto_d;
        end
    end

    assign proto_err = proto_q;
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
module tb_mem_block_responder;

    logic         clk = 1'b0;
    logic         proc_reset;
    // Instance with default LATENCY=4.
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;
    // Instance with LATENCY=1.
    logic         rd1, wr1;
    logic [27:0]  addr1;
    logic [127:0] wdata1, rdata1;
    logic         ready1;
`ifdef MEM_PROTO_CHECK_EN
    logic         proto4, proto1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] PATTERN = 128'hCAFEF00D_89ABCDEF_01234567_DEADBEEF;
    localparam logic [127:0] A5      = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam logic [127:0] FIVES   = 128'h55555555_66666666_77777777_88888888;

    always #5 clk = ~clk;

    mem_block_responder #(.IDX_W(6), .LATENCY(4)) dut4 (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef MEM_PROTO_CHECK_EN
        ,
        .proto_err  (proto4)
`endif
    );

    mem_block_responder #(.IDX_W(6), .LATENCY(1)) dut1 (
        .clk        (clk),
        .proc_reset (proc_reset),
        .mem_read   (rd1),
        .mem_write  (wr1),
        .mem_addr   (addr1),
        .mem_wdata  (wdata1),
        .mem_rdata  (rdata1),
        .mem_ready  (ready1)
`ifdef MEM_PROTO_CHECK_EN
        ,
        .proto_err  (proto1)
`endif
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on the LATENCY=4 instance. The request is driven
    // just after an edge, so the next edge is the sampling edge E0. mem_ready
    // is expected to be seen after E0+4, i.e. after 5 edges.
    task automatic txn4(input string tag, input logic rd, input logic wr,
                        input logic [27:0] addr, input logic [127:0] wd,
                        input logic [127:0] exp);
        int  edges = 0;
        bit  seen  = 1'b0;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr;
        mem_wdata = wd;
        while (!seen && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (mem_ready) seen = 1'b1;
        end
        check_eq({tag, "_ready_seen"}, 128'(seen), 128'd1);
        check_eq({tag, "_latency_edges"}, 128'(edges), 128'd5);
        check_eq({tag, "_rdata"}, mem_rdata, exp);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        check_eq({tag, "_ready_drop"}, 128'(mem_ready), 128'd0);
        check_eq({tag, "_rdata_clear"}, mem_rdata, 128'd0);
    endtask

    initial begin
        int pulses[$];
        int edges;
        bit seen;
        int ready_count;

        proc_reset = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; mem_addr = 28'd0; mem_wdata = 128'd0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 28'd0; wdata1 = 128'd0;
        repeat (3) @(posedge clk);
        #1 proc_reset = 1'b0;

        // Reset state.
        check_eq("rst_ready4", 128'(mem_ready), 128'd0);
        check_eq("rst_rdata4", mem_rdata, 128'd0);
        check_eq("rst_ready1", 128'(ready1), 128'd0);
        check_eq("rst_rdata1", rdata1, 128'd0);
`ifdef MEM_PROTO_CHECK_EN
        check_eq("rst_proto4", 128'(proto4), 128'd0);
`endif

        // Read of a never-written block returns zero.
        txn4("rd5", 1'b1, 1'b0, 28'h0000005, 128'd0, 128'd0);
        // mem_ready must pulse only once.
        @(posedge clk); #1;
        check_eq("rd5_single_pulse", 128'(mem_ready), 128'd0);

        // Write, then read back.
        txn4("wr3", 1'b0, 1'b1, 28'h0000003, PATTERN, PATTERN);
        txn4("rd3", 1'b1, 1'b0, 28'h0000003, 128'd0, PATTERN);

        // Aliasing: 0x040 maps onto block 0.
        txn4("wr40", 1'b0, 1'b1, 28'h0000040, A5, A5);
        txn4("rd0_alias", 1'b1, 1'b0, 28'h0000000, 128'd0, A5);
        // Unrelated block is unaffected.
        txn4("rd3_again", 1'b1, 1'b0, 28'h0000003, 128'd0, PATTERN);

`ifdef MEM_PROTO_CHECK_EN
        check_eq("proto_clean", 128'(proto4), 128'd0);
`endif
        // Read and write both high: treated as a write.
        txn4("rdwr7", 1'b1, 1'b1, 28'h0000007, 128'd1, 128'd1);
        txn4("rd7", 1'b1, 1'b0, 28'h0000007, 128'd0, 128'd1);
`ifdef MEM_PROTO_CHECK_EN
        check_eq("proto_both", 128'(proto4), 128'd1);
`endif

        // Reset while a write to block 2 is in BUSY.
        mem_write = 1'b1; mem_addr = 28'h0000002; mem_wdata = PATTERN;
        @(posedge clk);             // E0: sampled
        @(posedge clk); #1;         // E1: BUSY
        check_eq("busy_no_ready", 128'(mem_ready), 128'd0);
        proc_reset = 1'b1;
        @(posedge clk); #1;         // reset edge
        proc_reset = 1'b0;
        mem_write = 1'b0;
        ready_count = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (mem_ready) ready_count++;
        end
        check_eq("rst_busy_no_pulse", 128'(ready_count), 128'd0);
`ifdef MEM_PROTO_CHECK_EN
        check_eq("proto_rst", 128'(proto4), 128'd0);
`endif
        txn4("rd2_after_rst", 1'b1, 1'b0, 28'h0000002, 128'd0, 128'd0);
        txn4("rd3_after_rst", 1'b1, 1'b0, 28'h0000003, 128'd0, 128'd0);

        // LATENCY=1: write block 1. mem_ready is expected after E0+1.
        wr1 = 1'b1; addr1 = 28'h0000001; wdata1 = FIVES;
        edges = 0; seen = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (ready1) seen = 1'b1;
        end
        check_eq("l1_wr_seen", 128'(seen), 128'd1);
        check_eq("l1_wr_latency_edges", 128'(edges), 128'd2);
        check_eq("l1_wr_rdata", rdata1, FIVES);
        wr1 = 1'b0;
        @(posedge clk); #1;
        check_eq("l1_wr_drop", 128'(ready1), 128'd0);

        // LATENCY=1 back-to-back reads with the request held high.
        rd1 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (ready1) begin
                pulses.push_back(i);
                check_eq("l1_rd_pulse_data", rdata1, FIVES);
            end else begin
                check_eq("l1_rd_gap_zero", rdata1, 128'd0);
            end
        end
        rd1 = 1'b0;
        check_eq("l1_pulse_count", 128'(pulses.size()), 128'd4);
        if (pulses.size() >= 3) begin
            check_eq("l1_first_pulse", 128'(pulses[0]), 128'd2);
            check_eq("l1_spacing_a", 128'(pulses[1] - pulses[0]), 128'd3);
            check_eq("l1_spacing_b", 128'(pulses[2] - pulses[1]), 128'd3);
        end
`ifdef MEM_PROTO_CHECK_EN
        check_eq("l1_proto", 128'(proto1), 128'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
